// File: rtl/mips_pipeline_pkg.sv
// mips_pipeline_pkg: stage control/data bundle types, NOP control constants, and entry-count helper.
package mips_pipeline_pkg;
  typedef struct packed {
    logic       register_write;
    logic       memory_to_register;
    logic       memory_write;
    logic       alu_source;
    logic       register_destination;
    logic       halt;
    logic [5:0] alu_op;
    logic [3:0] hi_lo_op;
  } ctrl_execute_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;
    logic [31:0] immediate;
  } data_execute_t;
  typedef struct packed {
    logic       register_write;
    logic       memory_to_register;
    logic       memory_write;
    logic       halt;
  } ctrl_memory_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [4:0]  write_register;
  } data_memory_t;
  typedef struct packed {
    logic       register_write;
    logic       memory_to_register;
    logic       halt;
  } ctrl_writeback_t;
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [4:0]  write_register;
  } data_writeback_t;
  localparam ctrl_execute_t   CTRL_EXECUTE_NOP   = '0;
  localparam ctrl_memory_t    CTRL_MEMORY_NOP    = '0;
  localparam ctrl_writeback_t CTRL_WRITEBACK_NOP = '0;
  function automatic logic [1:0] entry_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction
endpackage

// File: rtl/pipeline_skid_entry.sv
// pipeline_skid_entry: one valid+control+data register; kill returns control to its bubble value.
module pipeline_skid_entry #(
  parameter int CTRL_WIDTH = 16,
  parameter int DATA_WIDTH = 128,
  parameter logic [CTRL_WIDTH-1:0] CTRL_RESET = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  kill,
  input  logic                  zero_data,
  input  logic [CTRL_WIDTH-1:0] ctrl_d,
  input  logic [DATA_WIDTH-1:0] data_d,
  output logic                  valid,
  output logic [CTRL_WIDTH-1:0] ctrl_q,
  output logic [DATA_WIDTH-1:0] data_q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid  <= 1'b0;
      ctrl_q <= CTRL_RESET;
      data_q <= '0;
    end else if (kill) begin
      valid  <= 1'b0;
      ctrl_q <= CTRL_RESET;
      data_q <= zero_data ? '0 : data_q;
    end else if (load) begin
      valid  <= 1'b1;
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
endmodule

// File: rtl/pipeline_stage_register.sv
// pipeline_stage_register: elastic valid/ready stage with main+skid entries, flush and occupancy.
module pipeline_stage_register
  import mips_pipeline_pkg::*;
#(
  parameter int CTRL_WIDTH = $bits(ctrl_execute_t),
  parameter int DATA_WIDTH = $bits(data_execute_t),
  parameter logic [CTRL_WIDTH-1:0] CTRL_RESET = CTRL_WIDTH'(CTRL_EXECUTE_NOP),
  parameter bit DATA_ZERO_ON_FLUSH = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] ctrl_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] ctrl_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            occupancy
);
  logic                  skid_valid;
  logic [CTRL_WIDTH-1:0] skid_ctrl;
  logic [DATA_WIDTH-1:0] skid_data;
  logic accept, fire, zero_data;
  logic main_load, main_kill, skid_load, skid_kill;
  // in_ready sees only registered state and flush, never out_ready
  assign in_ready  = ~skid_valid & ~flush;
  assign accept    = in_valid & in_ready;
  assign fire      = out_valid & out_ready;
  assign zero_data = flush & DATA_ZERO_ON_FLUSH;
  assign main_load = ~flush & (fire ? (skid_valid | accept) : (~out_valid & accept));
  assign main_kill = flush | (fire & ~skid_valid & ~accept);
  assign skid_load = ~flush & ~fire & out_valid & accept;
  assign skid_kill = flush | (fire & skid_valid);
  assign occupancy = entry_count(out_valid, skid_valid);
  pipeline_skid_entry #(
    .CTRL_WIDTH(CTRL_WIDTH), .DATA_WIDTH(DATA_WIDTH), .CTRL_RESET(CTRL_RESET)
  ) u_main (
    .clk(clk), .reset(reset), .load(main_load), .kill(main_kill), .zero_data(zero_data),
    .ctrl_d(skid_valid ? skid_ctrl : ctrl_in), .data_d(skid_valid ? skid_data : data_in),
    .valid(out_valid), .ctrl_q(ctrl_out), .data_q(data_out)
  );
  pipeline_skid_entry #(
    .CTRL_WIDTH(CTRL_WIDTH), .DATA_WIDTH(DATA_WIDTH), .CTRL_RESET(CTRL_RESET)
  ) u_skid (
    .clk(clk), .reset(reset), .load(skid_load), .kill(skid_kill), .zero_data(zero_data),
    .ctrl_d(ctrl_in), .data_d(data_in),
    .valid(skid_valid), .ctrl_q(skid_ctrl), .data_q(skid_data)
  );
endmodule

// File: tb/tb_pipeline_stage_register.sv
// tb_pipeline_stage_register: directed and random handshake checks against a queue scoreboard.
module tb_pipeline_stage_register;
  typedef struct packed {
    logic [15:0]  c;
    logic [127:0] d;
  } beat_t;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [15:0]  ctrl_in = '0;
  logic [127:0] data_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [15:0]  ctrl_out;
  logic [127:0] data_out;
  logic [1:0]   occupancy;
  int total = 0;
  int bad = 0;
  beat_t q[$];
  pipeline_stage_register dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_in(ctrl_in), .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .ctrl_out(ctrl_out), .data_out(data_out), .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [15:0] v, input logic iv, input logic ordy, input logic fl);
    ctrl_in   = v;
    data_in   = {8{v}};
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
  endtask
  // called at a falling edge with inputs already driven; checks, updates model, advances one cycle
  task automatic step();
    int n;
    #1;
    n = q.size();
    chk("occupancy", 128'(occupancy), 128'(n));
    chk("out_valid", 128'(out_valid), 128'(n != 0));
    chk("ctrl_out", 128'(ctrl_out), n != 0 ? 128'(q[0].c) : 128'(0));
    if (n != 0) chk("data_out", data_out, q[0].d);
    chk("in_ready", 128'(in_ready), 128'(n < 2 && !flush));
    if (flush) q.delete();
    else begin
      if (out_ready && n != 0) void'(q.pop_front());
      if (in_valid && n < 2) q.push_back('{ctrl_in, data_in});
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    #3;
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_occupancy", 128'(occupancy), 128'(0));
    chk("reset_ctrl_out", 128'(ctrl_out), 128'(0));
    chk("reset_data_out", data_out, 128'(0));
    @(negedge clk);
    reset = 1'b0;
    for (int v = 1; v <= 8; v++) begin
      drive(16'(v), 1'b1, 1'b1, 1'b0);
      step();
    end
    repeat (3) begin drive(16'h0, 1'b0, 1'b1, 1'b0); step(); end
    drive(16'h000A, 1'b1, 1'b0, 1'b0); step();
    drive(16'h000B, 1'b1, 1'b0, 1'b0); step();
    drive(16'h000C, 1'b1, 1'b0, 1'b0); step();
    repeat (2) begin drive(16'h0, 1'b0, 1'b0, 1'b0); step(); end
    repeat (3) begin drive(16'h0, 1'b0, 1'b1, 1'b0); step(); end
    drive(16'h000A, 1'b1, 1'b0, 1'b0); step();
    drive(16'h000B, 1'b1, 1'b0, 1'b0); step();
    drive(16'hFFFF, 1'b1, 1'b0, 1'b1); step();
    drive(16'h0, 1'b0, 1'b0, 1'b0); step();
    chk("flush_data_held", data_out, {8{16'h000A}});
    drive(16'h0011, 1'b1, 1'b0, 1'b0); step();
    drive(16'h0012, 1'b1, 1'b1, 1'b0); step();
    drive(16'h0013, 1'b1, 1'b0, 1'b0); step();
    drive(16'h0014, 1'b0, 1'b1, 1'b0); step();
    repeat (2) begin drive(16'h0, 1'b0, 1'b1, 1'b0); step(); end
    drive(16'h0021, 1'b1, 1'b0, 1'b0); step();
    drive(16'h0022, 1'b1, 1'b0, 1'b0); step();
    drive(16'h0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("async_out_valid", 128'(out_valid), 128'(0));
    chk("async_occupancy", 128'(occupancy), 128'(0));
    chk("async_ctrl_out", 128'(ctrl_out), 128'(0));
    chk("async_data_out", data_out, 128'(0));
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    step();
    for (int i = 0; i < 10000; i++) begin
      drive(16'($urandom), 1'($urandom), 1'($urandom), $urandom_range(63) == 0);
      step();
    end
    repeat (4) begin drive(16'h0, 1'b0, 1'b1, 1'b0); step(); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
